// File: rtl/fft_pkg.sv
// Shared definitions for the FFT bit-reversal reorder buffer: width helpers,
// the bit-reverse address function and the read-side state encoding.
package fft_pkg;

  // Widest address supported (NFFT up to 1024).
  localparam int MAX_ADDR_WIDTH = 10;

  // Default configuration: 6.12 fixed-point components, 64-point frames.
  localparam int DEFAULT_INTEGER_SIZE = 6;
  localparam int DEFAULT_FRACT_SIZE   = 12;
  localparam int DEFAULT_NFFT         = 64;
  localparam int DATA_WIDTH           = DEFAULT_INTEGER_SIZE + DEFAULT_FRACT_SIZE;
  localparam int ADDR_WIDTH           = $clog2(DEFAULT_NFFT);

  // Read-side sequencer states.
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Width of one sample component for a given fixed-point split.
  function automatic int data_width(input int integer_size, input int fract_size);
    return integer_size + fract_size;
  endfunction

  // Address width for a power-of-two frame length.
  function automatic int addr_width(input int nfft);
    return $clog2(nfft);
  endfunction

  // Reverse the low 'width' bits of k; upper result bits are zero.
  // The full field is mirrored and then shifted down, which keeps every
  // bit select constant for any width.
  function automatic logic [MAX_ADDR_WIDTH-1:0] bitrev(
    input logic [MAX_ADDR_WIDTH-1:0] k,
    input int                        width
  );
    logic [MAX_ADDR_WIDTH-1:0] mirrored;
    for (int b = 0; b < MAX_ADDR_WIDTH; b++) begin
      mirrored[b] = k[MAX_ADDR_WIDTH-1-b];
    end
    return mirrored >> (MAX_ADDR_WIDTH - width);
  endfunction

endpackage

// File: rtl/reorder_bank_ram.sv
// Ping-pong sample store: two banks of 2**ADDR_WIDTH complex words. The bank
// select is the address MSB. One synchronous write port, one combinational
// read port.
module reorder_bank_ram
  import fft_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = DATA_WIDTH,
  parameter int RAM_ADDR_WIDTH = ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             wr_en,
  input  logic        [RAM_ADDR_WIDTH:0]   wr_addr,
  input  logic signed [RAM_DATA_WIDTH-1:0] wr_r,
  input  logic signed [RAM_DATA_WIDTH-1:0] wr_i,
  input  logic        [RAM_ADDR_WIDTH:0]   rd_addr,
  output logic signed [RAM_DATA_WIDTH-1:0] rd_r,
  output logic signed [RAM_DATA_WIDTH-1:0] rd_i
);

  localparam int DEPTH = 2 ** (RAM_ADDR_WIDTH + 1);

  logic signed [RAM_DATA_WIDTH-1:0] mem_r [DEPTH];
  logic signed [RAM_DATA_WIDTH-1:0] mem_i [DEPTH];

  // Capture one complex word per write strobe.
  // NOTE: the arrays have no reset; a bank is always completely rewritten
  // before the reader is allowed to look at it, so stale contents never leak.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_r;
      mem_i[wr_addr] <= wr_i;
    end
  end

  // Asynchronous read; the top registers the result.
  assign rd_r = mem_r[rd_addr];
  assign rd_i = mem_i[rd_addr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for streaming FFT output.
// Input sample k lands at address bitrev(k) of the write bank; a full bank is
// read out sequentially while the other bank fills.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter  int INTEGER_SIZE = 6,
  parameter  int FRACT_SIZE   = 12,
  parameter  int NFFT         = 64,
  localparam int DW           = data_width(INTEGER_SIZE, FRACT_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  output logic                 out_valid,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic                 sync_err
);

  localparam int                AW        = addr_width(NFFT);
  localparam logic [AW-1:0]     LAST_ADDR = AW'(NFFT - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Write side
  logic [AW-1:0] wr_cnt_q,  wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic          armed_q,   armed_d;    // waiting for the first in_sof
  logic          sync_err_q, sync_err_d;
  logic [1:0]    full_q,    full_d;     // per-bank "frame complete" flags

  // Read side
  rd_state_e     state_q,   state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_bank_q, rd_bank_d;

  // Registered outputs
  logic          out_valid_q, out_valid_d;
  logic          out_sof_q,   out_sof_d;
  logic          out_eof_q,   out_eof_d;
  logic signed [DW-1:0] out_r_q, out_r_d;
  logic signed [DW-1:0] out_i_q, out_i_d;

  // Combinational strobes between the halves
  logic          wr_en;
  logic [AW-1:0] wr_k;
  logic          wr_set_full;
  logic          rd_en;
  logic          rd_last;
  logic          rd_bank_other;

  logic [AW:0]          ram_wr_addr;
  logic [AW:0]          ram_rd_addr;
  logic signed [DW-1:0] ram_rd_r;
  logic signed [DW-1:0] ram_rd_i;

  // ---------------------------------------------------------------------------
  // Write side: sample index tracking, frame start / abort, bank swap
  // ---------------------------------------------------------------------------
  // Next-state for the write counter, bank select and sof-wait flag.
  // NOTE: every variable gets a default at the top of a combinational block so
  // no path leaves one unassigned and a latch is never inferred.
  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    armed_d     = armed_q;
    sync_err_d  = 1'b0;
    wr_en       = 1'b0;
    wr_set_full = 1'b0;
    wr_k        = wr_cnt_q;

    if (in_valid) begin
      if (in_sof) begin
        // A start-of-frame always restarts at k=0 in the current bank; if a
        // frame was already partly written it is dropped and flagged.
        sync_err_d = !armed_q && (wr_cnt_q != '0);
        armed_d    = 1'b0;
        wr_k       = '0;
        wr_en      = 1'b1;
      end else if (!armed_q) begin
        wr_en      = 1'b1;
      end

      if (wr_en) begin
        if (wr_k == LAST_ADDR) begin
          wr_cnt_d    = '0;
          wr_bank_d   = ~wr_bank_q;
          wr_set_full = 1'b1;
        end else begin
          wr_cnt_d    = wr_k + AW'(1);
        end
      end
    end
  end

  assign ram_wr_addr = {wr_bank_q, AW'(bitrev(MAX_ADDR_WIDTH'(wr_k), AW))};

  // ---------------------------------------------------------------------------
  // Read side: IDLE/READ sequencer
  // ---------------------------------------------------------------------------
  assign rd_bank_other = ~rd_bank_q;

  // Sequence reads through the full bank. Address 0 is launched on the
  // IDLE->READ edge itself so sample 0 is registered one cycle after the
  // bank fills; READ then walks the remaining addresses. At the last address
  // the sequencer chains straight into the other bank if it is already full.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_bank_d = rd_bank_q;
    rd_en     = 1'b0;
    rd_last   = 1'b0;

    unique case (state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_en     = 1'b1;
          rd_addr_d = AW'(1);
          state_d   = RD_READ;
        end
      end
      RD_READ: begin
        rd_en = 1'b1;
        if (rd_addr_q == LAST_ADDR) begin
          rd_last   = 1'b1;
          rd_addr_d = '0;
          rd_bank_d = rd_bank_other;
          state_d   = full_q[rd_bank_other] ? RD_READ : RD_IDLE;
        end else begin
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      default: begin
        state_d   = RD_IDLE;
        rd_addr_d = '0;
      end
    endcase
  end

  assign ram_rd_addr = {rd_bank_q, rd_addr_q};

  // Bank-full flags: the reader releases its bank on the last read, the
  // writer claims its bank on the last write. They never target the same bank
  // in the same cycle because the writer always works on the other bank.
  always_comb begin
    full_d = full_q;
    if (rd_last) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (wr_set_full) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  // Output register inputs: data is forced to zero outside valid cycles.
  always_comb begin
    out_valid_d = rd_en;
    out_sof_d   = rd_en && (rd_addr_q == '0);
    out_eof_d   = rd_en && (rd_addr_q == LAST_ADDR);
    out_r_d     = rd_en ? ram_rd_r : '0;
    out_i_d     = rd_en ? ram_rd_i : '0;
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  reorder_bank_ram #(
    .RAM_DATA_WIDTH (DW),
    .RAM_ADDR_WIDTH (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (ram_wr_addr),
    .wr_r    (in_r),
    .wr_i    (in_i),
    .rd_addr (ram_rd_addr),
    .rd_r    (ram_rd_r),
    .rd_i    (ram_rd_i)
  );

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // All control and output state; reset discards any frame in flight.
  // NOTE: clocked state uses non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      armed_q     <= 1'b1;
      sync_err_q  <= 1'b0;
      full_q      <= '0;
      state_q     <= RD_IDLE;
      rd_addr_q   <= '0;
      rd_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      armed_q     <= armed_d;
      sync_err_q  <= sync_err_d;
      full_q      <= full_d;
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rd_bank_q   <= rd_bank_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder (NFFT=64, 18-bit components).
module tb_fft_bitrev_reorder;

  localparam int N  = 64;
  localparam int DW = 18;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_sof;
  logic signed [DW-1:0] in_r;
  logic signed [DW-1:0] in_i;
  logic                 out_valid;
  logic                 out_sof;
  logic                 out_eof;
  logic signed [DW-1:0] out_r;
  logic signed [DW-1:0] out_i;
  logic                 sync_err;

  fft_bitrev_reorder dut (
    .clk       (clk),
    .rst       (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_r      (in_r),
    .in_i      (in_i),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .out_r     (out_r),
    .out_i     (out_i),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [DW-1:0] r;
    logic signed [DW-1:0] i;
  } samp_t;

  typedef struct {
    int pattern;
    int n_frames;
    int gap_every;
    int exp_max_run;
  } vec_t;

  samp_t exp_q[$];
  int    lat_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int n_sof    = 0;
  int n_eof    = 0;
  int n_sync   = 0;
  int mon_idx  = 0;
  int run_len  = 0;
  int max_run  = 0;
  int gcnt     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [5:0] brev6(input logic [5:0] k);
    logic [5:0] r;
    for (int b = 0; b < 6; b++) r[b] = k[5-b];
    return r;
  endfunction

  // Input sample for frame index k under a given pattern.
  function automatic void gen(input int pat, input int k,
                              output logic signed [DW-1:0] r, output logic signed [DW-1:0] i);
    logic [5:0] kk;
    kk = 6'(k);
    case (pat)
      0: begin r = DW'(brev6(kk)); i = DW'(-k); end
      1: begin
        r = kk[0] ? 18'h1FFFF : 18'h20000;
        i = kk[0] ? 18'h20000 : 18'h1FFFF;
      end
      2: begin r = DW'(((k + 1) * 40503) ^ 32'h15A5A); i = DW'((k + 7) * 9973 + 12345); end
      default: begin r = DW'(k); i = DW'(3 * k - 100); end
    endcase
  endfunction

  task automatic send(input logic sof, input logic signed [DW-1:0] r, input logic signed [DW-1:0] i);
    in_valid = 1'b1; in_sof = sof; in_r = r; in_i = i;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0; in_sof = 1'b0; in_r = '0; in_i = '0;
    @(posedge clk); #1;
  endtask

  task automatic go_idle();
    in_valid = 1'b0; in_sof = 1'b0; in_r = '0; in_i = '0;
  endtask

  // Drive nsamp samples of one frame (sof on k=0). When push is set the whole
  // natural-order frame and its expected sof cycle go to the scoreboard.
  task automatic drive_frame(input int pat, input int gap_every, input int nsamp, input bit push);
    logic signed [DW-1:0] r, i, er, ei;
    for (int k = 0; k < nsamp; k++) begin
      while (gap_every > 0 && (gcnt % gap_every) == gap_every - 1) begin
        idle_cycle();
        gcnt++;
      end
      gen(pat, k, r, i);
      if (push && k == N - 1) begin
        lat_q.push_back(cyc + 2);
        for (int n = 0; n < N; n++) begin
          gen(pat, int'(brev6(6'(n))), er, ei);
          exp_q.push_back('{er, ei});
        end
      end
      send(k == 0, r, i);
      gcnt++;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 400; t++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(negedge clk); #1;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  // Output monitor / scoreboard consumer.
  initial begin
    samp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("data_n%0d", mon_idx), {28'd0, out_r, out_i}, {28'd0, e.r, e.i});
        end
        check($sformatf("sof_n%0d", mon_idx), 64'(out_sof), 64'(mon_idx == 0));
        check($sformatf("eof_n%0d", mon_idx), 64'(out_eof), 64'(mon_idx == N - 1));
        if (out_sof) begin
          n_sof++;
          if (lat_q.size() == 0) check("latency_unexpected", 64'd1, 64'd0);
          else check("latency_cycle", 64'(cyc), 64'(lat_q.pop_front()));
        end
        if (out_eof) n_eof++;
        mon_idx = (mon_idx == N - 1) ? 0 : mon_idx + 1;
      end else begin
        run_len = 0;
        if (mon_idx != 0) begin
          check("frame_gap", 64'(mon_idx), 64'd0);
          mon_idx = 0;
        end
        check("idle_zero", {26'd0, out_r, out_i, out_sof, out_eof}, 64'd0);
      end
      if (sync_err) n_sync++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];

  initial begin
    int s0, e0, y0;
    vecs[0] = '{0, 1, 0, 64};   // ramp frame, latency and sof/eof placement
    vecs[1] = '{0, 4, 0, 256};  // four back-to-back frames, no output gap
    vecs[2] = '{0, 2, 3, 64};   // in_valid low every 3rd cycle
    vecs[3] = '{1, 1, 0, 64};   // extreme positive / negative codes
    vecs[4] = '{2, 3, 0, 192};  // scrambled data, back-to-back
    vecs[5] = '{3, 2, 5, 64};   // sparse gaps, second data pattern

    rst_n = 1'b0;
    go_idle();
    #3;
    check("reset_outputs", {24'd0, out_valid, out_sof, out_eof, sync_err, out_r, out_i}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven frame scenarios
    for (int v = 0; v < 6; v++) begin
      max_run = 0; s0 = n_sof; e0 = n_eof; y0 = n_sync; gcnt = 0;
      for (int f = 0; f < vecs[v].n_frames; f++) begin
        drive_frame(vecs[v].pattern, vecs[v].gap_every, N, 1'b1);
      end
      go_idle();
      drain();
      check($sformatf("v%0d_sof_count", v), 64'(n_sof - s0), 64'(vecs[v].n_frames));
      check($sformatf("v%0d_eof_count", v), 64'(n_eof - e0), 64'(vecs[v].n_frames));
      check($sformatf("v%0d_max_run", v), 64'(max_run), 64'(vecs[v].exp_max_run));
      check($sformatf("v%0d_no_sync_err", v), 64'(n_sync - y0), 64'd0);
    end

    // Early in_sof at k=20 while the previous frame is still being read out
    y0 = n_sync; s0 = n_sof; gcnt = 0;
    drive_frame(3, 0, N, 1'b1);
    drive_frame(2, 0, 20, 1'b0);
    drive_frame(0, 0, N, 1'b1);
    go_idle();
    drain();
    check("abort_sync_pulses", 64'(n_sync - y0), 64'd1);
    check("abort_frames_out", 64'(n_sof - s0), 64'd2);

    // Reset in the middle of an output frame
    gcnt = 0;
    drive_frame(2, 0, N, 1'b1);
    go_idle();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); #1;
      if (mon_idx == 31) break;
    end
    check("reset_point_reached", 64'(mon_idx), 64'd31);
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs", {24'd0, out_valid, out_sof, out_eof, sync_err, out_r, out_i}, 64'd0);
    exp_q.delete();
    lat_q.delete();
    mon_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Samples without a preceding in_sof after reset must be ignored
    y0 = n_sync; s0 = n_sof;
    for (int k = 0; k < 70; k++) begin
      logic signed [DW-1:0] jr, ji;
      gen(2, k + 5, jr, ji);
      send(1'b0, jr, ji);
    end
    drive_frame(0, 0, N, 1'b1);
    go_idle();
    drain();
    check("post_reset_no_sync_err", 64'(n_sync - y0), 64'd0);
    check("post_reset_frames_out", 64'(n_sof - s0), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 SHALL have parameter INTEGER_SIZE, default 6, integer bits of each sample component.
REQ-002 SHALL have parameter FRACT_SIZE, default 12, fractional bits of each sample component.
REQ-003 SHALL have parameter NFFT, default 64, frame length (power of two, 8..1024).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  input sample present this cycle.
REQ-007 SHALL have port in_sof  input  1  qualifies the in_valid sample as frame sample 0.
REQ-008 SHALL have ports in_r, in_i  input  DATA_WIDTH signed  sample in bit-reversed order (DATA_WIDTH = INTEGER_SIZE+FRACT_SIZE).
REQ-009 SHALL have port out_valid  output  1  output sample present.
REQ-010 SHALL have ports out_sof, out_eof  output  1 each  first / last natural-order sample of a frame.
REQ-011 SHALL have ports out_r, out_i  output  DATA_WIDTH signed  sample in natural order.
REQ-012 SHALL have port sync_err  output  1  one-cycle pulse when a frame is aborted by early in_sof.

Function
REQ-013 SHALL hold two banks of NFFT complex words (ping-pong); one bank is written while the other is read.
REQ-014 SHALL write, on each in_valid cycle, input index k (write counter) at address bitrev(k) of the write bank, with bitrev over log2(NFFT) bits.
REQ-015 SHALL ignore in_valid samples until the first in_sof after reset; in_sof with in_valid starts a frame at k=0.
REQ-016 SHALL mark the write bank full and swap banks on the edge that captures k=NFFT-1; the write counter wraps to 0.
REQ-017 SHALL tolerate gaps (in_valid low) inside a frame; the write counter holds during gaps.
REQ-018 SHALL restart at k=0 in the same bank, discarding the partial frame and pulsing sync_err, when in_sof arrives with k != 0.
REQ-019 SHALL implement a read FSM with states IDLE and READ; IDLE->READ on bank-full; READ reads addresses 0..NFFT-1 sequentially, one per cycle.
REQ-020 SHALL leave READ only after address NFFT-1: to READ (address 0 of the other bank) if that bank is full that cycle, else to IDLE.
REQ-021 SHALL register outputs: out_valid and sample 0 appear one cycle after the edge capturing input k=NFFT-1.
REQ-022 SHALL assert out_valid for exactly NFFT consecutive cycles per frame, out_sof on sample 0, out_eof on sample NFFT-1.
REQ-023 SHALL produce gap-free back-to-back output frames for continuous input (in_valid held high).
REQ-024 SHALL pass data bit-exactly; no rounding, saturation or width change.
REQ-025 SHALL drive out_r/out_i to 0 whenever out_valid is low.
REQ-026 SHALL complete a frame being read even if sync_err occurs meanwhile; the write-side restart does not affect the read bank.

Reset
REQ-027 SHALL, on rst low, immediately clear out_valid, out_sof, out_eof, sync_err, out_r, out_i, both counters, bank select, full flags, and return to IDLE with sof-wait armed.
REQ-028 SHALL discard any frame in progress on reset mid-operation; bank contents need not be cleared.
REQ-029 SHALL start operating on the first rising edge after rst deasserts.

Structure
REQ-030 SHALL take DATA_WIDTH, ADDR_WIDTH = clog2(NFFT) and a bitrev function from shared package fft_pkg.
REQ-031 SHALL place storage in one sub-module reorder_bank_ram (two banks, one write port, one combinational read port, bank-select bit as address MSB).

Verification (NFFT=64)
REQ-032 SHALL check: continuous frame with in_r = bitrev6(k), in_i = -k -> out_r = 0..63 in order, in_i = -bitrev6(n), latency exactly 1 cycle after input 63, out_sof/out_eof on n=0/63.
REQ-033 SHALL check: 4 back-to-back frames, continuous in_valid -> 256 consecutive out_valid cycles, no gap, 4 sof/eof pairs.
REQ-034 SHALL check: input with in_valid low on every 3rd cycle -> identical output data, each output frame contiguous 64 cycles.
REQ-035 SHALL check: in_sof at k=20 -> sync_err pulses once, first 20 samples dropped, next full frame reordered correctly.
REQ-036 SHALL check: rst low at output sample 30 -> all outputs 0 within the reset cycle; samples before first post-reset in_sof ignored.
REQ-037 SHALL check: extreme values 0x1FFFF and 0x20000 (18-bit) on both components -> reproduced unchanged at bit-reversed positions.
